// File: rtl/spi_mem_pkg.sv
// Shared types and helpers for the SPI burst memory slave.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    ARMED,
    IDLE,
    HEADER,
    FETCH,
    READ,
    WRITE,
    COMMIT,
    DRAIN
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Header frame is the address followed by the single read/write bit.
  function automatic int hdr_len(input int addr_w);
    return addr_w + 1;
  endfunction

  // Counter must hold the longer of the header and data word lengths.
  function automatic int cnt_width(input int addr_w, input int data_w);
    int longest;
    longest = (addr_w + 1 > data_w) ? (addr_w + 1) : data_w;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/spi_mem_ram.sv
// Single-port synchronous RAM with one-cycle registered read.
// The read data register only updates when re is asserted, so a
// prefetched word stays available until it is consumed.
module spi_mem_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write and gated registered read share the single address port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_mem_burst.sv
// SPI mode-0 slave memory with configurable address/data width.
// Optional feature macro SPI_MEM_BURST_EN: when defined, reads and
// writes auto-increment the address until chip select rises; when
// undefined, exactly one word is transferred per transaction and the
// rest of the transaction drains.
module spi_mem_burst
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic mosi,
  input  logic sclk_posedge,
  input  logic sclk_negedge,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  output logic word_done
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int HDR_LEN = hdr_len(ADDR_W);
  localparam int CNT_W   = cnt_width(ADDR_W, DATA_W);

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

`ifdef SPI_MEM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W-1:0] hdr, hdr_nxt;
  logic [DATA_W-1:0] rx, rx_nxt;
  logic [DATA_W-1:0] tx, tx_nxt;
  logic              miso_nxt, miso_oe_nxt, word_done_nxt;
  logic              load_pend, load_pend_nxt;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  spi_mem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(rx),
    .rdata(ram_rdata)
  );

  // ARMED exists only to swallow a transaction caught mid-flight by reset.
  assign busy = (state != IDLE) && (state != ARMED);

  // State and datapath registers; the RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARMED;
      bit_cnt   <= '0;
      addr      <= '0;
      hdr       <= '0;
      rx        <= '0;
      tx        <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      word_done <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      addr      <= addr_nxt;
      hdr       <= hdr_nxt;
      rx        <= rx_nxt;
      tx        <= tx_nxt;
      miso      <= miso_nxt;
      miso_oe   <= miso_oe_nxt;
      word_done <= word_done_nxt;
      load_pend <= load_pend_nxt;
    end
  end

  // Next-state, datapath and RAM control; posedge strobes take priority
  // over negedge strobes, and a high chip select overrides everything.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    addr_nxt      = addr;
    hdr_nxt       = hdr;
    rx_nxt        = rx;
    tx_nxt        = tx;
    miso_nxt      = miso;
    miso_oe_nxt   = miso_oe;
    word_done_nxt = 1'b0;
    load_pend_nxt = load_pend;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_addr      = addr;

    case (state)
      ARMED: begin
        if (cs_n) begin
          state_nxt = IDLE;
        end
      end

      IDLE: begin
        if (!cs_n) begin
          state_nxt   = HEADER;
          bit_cnt_nxt = '0;
        end
      end

      HEADER: begin
        if (sclk_posedge) begin
          hdr_nxt = {hdr[ADDR_W-2:0], mosi};
          if (bit_cnt == HDR_LAST) begin
            // hdr already holds every address bit; mosi is the rw flag.
            addr_nxt    = hdr;
            bit_cnt_nxt = '0;
            state_nxt   = (mosi == RW_READ) ? FETCH : WRITE;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_ONE;
          end
        end
      end

      FETCH: begin
        if (bit_cnt == '0) begin
          ram_re      = 1'b1;
          bit_cnt_nxt = CNT_ONE;
        end else begin
          tx_nxt        = ram_rdata;
          bit_cnt_nxt   = '0;
          miso_oe_nxt   = 1'b1;
          load_pend_nxt = 1'b0;
          state_nxt     = READ;
          if (BURST) begin
            ram_re   = 1'b1;
            ram_addr = addr + ADDR_ONE;
          end
        end
      end

      READ: begin
        if (sclk_posedge) begin
          if (bit_cnt == DATA_LAST) begin
            word_done_nxt = 1'b1;
            bit_cnt_nxt   = '0;
            if (BURST) begin
              addr_nxt      = addr + ADDR_ONE;
              load_pend_nxt = 1'b1;
            end else begin
              state_nxt = DRAIN;
              miso_nxt  = 1'b0;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_ONE;
          end
        end else if (sclk_negedge) begin
          if (load_pend) begin
            // addr now names the prefetched word; fetch the one after it.
            miso_nxt      = ram_rdata[DATA_W-1];
            tx_nxt        = {ram_rdata[DATA_W-2:0], 1'b0};
            load_pend_nxt = 1'b0;
            ram_re        = 1'b1;
            ram_addr      = addr + ADDR_ONE;
          end else begin
            miso_nxt = tx[DATA_W-1];
            tx_nxt   = {tx[DATA_W-2:0], 1'b0};
          end
        end
      end

      WRITE: begin
        if (sclk_posedge) begin
          rx_nxt = {rx[DATA_W-2:0], mosi};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = COMMIT;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_ONE;
          end
        end
      end

      COMMIT: begin
        ram_we        = 1'b1;
        word_done_nxt = 1'b1;
        bit_cnt_nxt   = '0;
        if (BURST) begin
          addr_nxt  = addr + ADDR_ONE;
          state_nxt = WRITE;
        end else begin
          state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        state_nxt = DRAIN;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A completed word in COMMIT keeps its write; partial words are dropped.
    if (cs_n && (state != ARMED) && (state != IDLE)) begin
      state_nxt     = IDLE;
      miso_nxt      = 1'b0;
      miso_oe_nxt   = 1'b0;
      bit_cnt_nxt   = '0;
      load_pend_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_mem_burst.sv
// Directed bench for spi_mem_burst: a default 7/8 instance and a 4/16
// instance share the SCLK strobes and MOSI, each with its own chip select.
// Expectations follow SPI_MEM_BURST_EN when the bench is built with it.
module tb_spi_mem_burst;

  logic clk = 1'b0;
  logic rst_n, cs_n_a, cs_n_b, mosi, sclk_posedge, sclk_negedge;
  logic miso_a, miso_oe_a, busy_a, word_done_a;
  logic miso_b, miso_oe_b, busy_b, word_done_b;

  int total = 0;
  int bad   = 0;
  int wd_a  = 0;
  int wd_b  = 0;
  bit sel   = 1'b0;

  logic [15:0] wbuf [4];
  logic [15:0] rbuf [4];
  logic [7:0]  exp_rd [4];
  int          exp_wd_w;
  int          exp_wd_r;

  always #5 clk = ~clk;

  spi_mem_burst #(.ADDR_W(7), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n_a), .mosi(mosi),
    .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
    .miso(miso_a), .miso_oe(miso_oe_a), .busy(busy_a), .word_done(word_done_a)
  );

  spi_mem_burst #(.ADDR_W(4), .DATA_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n_b), .mosi(mosi),
    .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
    .miso(miso_b), .miso_oe(miso_oe_b), .busy(busy_b), .word_done(word_done_b)
  );

  // Count word_done pulses of each instance.
  always @(posedge clk) begin
    if (word_done_a) wd_a <= wd_a + 1;
    if (word_done_b) wd_b <= wd_b + 1;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One SCLK period: MISO is sampled just before the rising edge.
  task automatic bit_xfer(input logic b, output logic so);
    mosi = b;
    so = sel ? miso_b : miso_a;
    sclk_posedge = 1'b1;
    @(negedge clk);
    sclk_posedge = 1'b0;
    repeat (3) @(negedge clk);
    sclk_negedge = 1'b1;
    @(negedge clk);
    sclk_negedge = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic cs_set(input logic v);
    if (sel) cs_n_b = v;
    else     cs_n_a = v;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_header(input logic [15:0] a, input logic rw);
    logic dummy;
    int aw;
    aw = sel ? 4 : 7;
    for (int i = aw - 1; i >= 0; i--) bit_xfer(a[i], dummy);
    bit_xfer(rw, dummy);
  endtask

  // Full transaction of n words; writes take wbuf, reads fill rbuf.
  task automatic apply_stimulus(input bit s, input logic [15:0] a,
                                input logic rw, input int n);
    logic b;
    int dw;
    sel = s;
    dw = s ? 16 : 8;
    cs_set(1'b0);
    send_header(a, rw);
    if (rw) check_output("oe_in_read", {31'd0, s ? miso_oe_b : miso_oe_a}, 32'd1);
    for (int w = 0; w < n; w++) begin
      rbuf[w] = '0;
      for (int i = dw - 1; i >= 0; i--) begin
        bit_xfer(wbuf[w][i], b);
        rbuf[w][i] = b;
      end
    end
    cs_set(1'b1);
  endtask

  task automatic write1(input bit s, input logic [15:0] a, input logic [15:0] d);
    wbuf[0] = d;
    apply_stimulus(s, a, 1'b0, 1);
  endtask

  task automatic read1(input bit s, input logic [15:0] a);
    wbuf[0] = '0;
    apply_stimulus(s, a, 1'b1, 1);
  endtask

  initial begin
    int w0;
    logic dummy;
`ifdef SPI_MEM_BURST_EN
    exp_rd   = '{8'h22, 8'h33, 8'hC1, 8'hC2};
    exp_wd_w = 3;
    exp_wd_r = 4;
`else
    exp_rd   = '{8'h77, 8'h00, 8'h00, 8'h00};
    exp_wd_w = 1;
    exp_wd_r = 1;
`endif
    rst_n = 1'b0; cs_n_a = 1'b1; cs_n_b = 1'b1; mosi = 1'b0;
    sclk_posedge = 1'b0; sclk_negedge = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    check_output("rst_miso", {31'd0, miso_a}, 32'd0);
    check_output("rst_oe", {31'd0, miso_oe_a}, 32'd0);
    check_output("rst_busy", {31'd0, busy_a}, 32'd0);
    check_output("rst_wd", {31'd0, word_done_a}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single write/read");
    w0 = wd_a;
    write1(0, 16'h05, 16'h00A5);
    check_output("wr_wd", w0 == wd_a ? 0 : wd_a - w0, 32'd1);
    check_output("wr_busy_after", {31'd0, busy_a}, 32'd0);
    w0 = wd_a;
    read1(0, 16'h05);
    check_output("rd_05", {16'd0, rbuf[0]}, 32'hA5);
    check_output("rd_wd", wd_a - w0, 32'd1);
    check_output("oe_after_cs", {31'd0, miso_oe_a}, 32'd0);

    $display("[TB] burst write with wrap");
    write1(0, 16'h7F, 16'h0077);
    write1(0, 16'h00, 16'h0070);
    write1(0, 16'h01, 16'h00C1);
    write1(0, 16'h02, 16'h00C2);
    wbuf = '{16'h0011, 16'h0022, 16'h0033, 16'h0000};
    w0 = wd_a;
    apply_stimulus(0, 16'h7E, 1'b0, 3);
    check_output("bw_wd", wd_a - w0, exp_wd_w);
    read1(0, 16'h7E);
    check_output("bw_7e", {16'd0, rbuf[0]}, 32'h11);

    $display("[TB] burst read across wrap");
    wbuf = '{16'h0, 16'h0, 16'h0, 16'h0};
    w0 = wd_a;
    apply_stimulus(0, 16'h7F, 1'b1, 4);
    check_output("br_w0", {16'd0, rbuf[0]}, {24'd0, exp_rd[0]});
    check_output("br_w1", {16'd0, rbuf[1]}, {24'd0, exp_rd[1]});
    check_output("br_w2", {16'd0, rbuf[2]}, {24'd0, exp_rd[2]});
    check_output("br_w3", {16'd0, rbuf[3]}, {24'd0, exp_rd[3]});
    check_output("br_wd", wd_a - w0, exp_wd_r);
    read1(0, 16'h00);
`ifdef SPI_MEM_BURST_EN
    check_output("bw_00", {16'd0, rbuf[0]}, 32'h33);
`else
    check_output("bw_00", {16'd0, rbuf[0]}, 32'h70);
`endif

    $display("[TB] abort mid-word");
    write1(0, 16'h10, 16'h005A);
    sel = 1'b0;
    cs_set(1'b0);
    send_header(16'h10, 1'b0);
    for (int i = 0; i < 5; i++) bit_xfer(1'b1, dummy);
    cs_n_a = 1'b1;
    @(negedge clk);
    check_output("abort_busy", {31'd0, busy_a}, 32'd0);
    repeat (2) @(negedge clk);
    read1(0, 16'h10);
    check_output("abort_mem", {16'd0, rbuf[0]}, 32'h5A);

    $display("[TB] reset mid-transaction");
    sel = 1'b0;
    cs_set(1'b0);
    send_header(16'h05, 1'b1);
    for (int i = 0; i < 3; i++) bit_xfer(1'b0, dummy);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("mrst_miso", {31'd0, miso_a}, 32'd0);
    check_output("mrst_oe", {31'd0, miso_oe_a}, 32'd0);
    rst_n = 1'b1;
    w0 = wd_a;
    for (int i = 0; i < 5; i++) bit_xfer(1'b0, dummy);
    check_output("mrst_busy", {31'd0, busy_a}, 32'd0);
    check_output("mrst_oe_held", {31'd0, miso_oe_a}, 32'd0);
    check_output("mrst_wd", wd_a - w0, 32'd0);
    cs_set(1'b1);
    read1(0, 16'h05);
    check_output("mrst_rd", {16'd0, rbuf[0]}, 32'hA5);

    $display("[TB] 4-bit address / 16-bit data instance");
    w0 = wd_b;
    write1(1, 16'h0F, 16'hBEEF);
    check_output("b_wd", wd_b - w0, 32'd1);
    read1(1, 16'h0F);
    check_output("b_rd", {16'd0, rbuf[0]}, 32'hBEEF);
    check_output("b_oe_after", {31'd0, miso_oe_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
